// File: rtl/pcie_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// pcie_ctrl_fsm
//   Master control FSM for the PCIE_trans datapath (main FIFO, VC0/VC1 and
//   D0/D1 FIFOs). It latches the FIFO thresholds while in INIT and hands
//   them to the FIFOs. It watches the FIFO empty/error flags and reports
//   the block status as idle/active/error.
//
// Ports
//   clk            in   single clock, posedge
//   reset_L        in   asynchronous active-low reset
//   init           in   request (re)initialisation / threshold load
//   umbral_*_in    in   thresholds from the probador side
//   fifo_empty     in   {D1,D0,VC1,VC0,MF} empty flags, bit0 = MF
//   fifo_error     in   overflow/underflow flags, same bit order
//   umbral_*       out  latched thresholds to the FIFOs
//   active_out     out  1 while in ACTIVE
//   idle_out       out  1 while in IDLE
//   error_out      out  1 while in ERROR
//   err_id         out  index of the FIFO that caused ERROR
//   state          out  current state code (debug)
//
// Handshake: there is no valid/ready pair here. The inputs are level
// signals that are sampled on every posedge. All outputs come from
// registers, so each output follows its triggering input by one clock.
// ---------------------------------------------------------------------------
module pcie_ctrl_fsm #(
    parameter int UMB_MF_W = 2,
    parameter int UMB_VC_W = 4,
    parameter int UMB_D_W  = 2,
    parameter int DEF_MF   = 1,
    parameter int DEF_VC   = 4,
    parameter int DEF_D    = 1
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic [UMB_MF_W-1:0] umbral_MF_in,
    input  logic [UMB_VC_W-1:0] umbral_VC0_in,
    input  logic [UMB_VC_W-1:0] umbral_VC1_in,
    input  logic [UMB_D_W-1:0]  umbral_D0_in,
    input  logic [UMB_D_W-1:0]  umbral_D1_in,
    input  logic [4:0]          fifo_empty,
    input  logic [4:0]          fifo_error,
    output logic [UMB_MF_W-1:0] umbral_MF,
    output logic [UMB_VC_W-1:0] umbral_VC0,
    output logic [UMB_VC_W-1:0] umbral_VC1,
    output logic [UMB_D_W-1:0]  umbral_D0,
    output logic [UMB_D_W-1:0]  umbral_D1,
    output logic                active_out,
    output logic                idle_out,
    output logic                error_out,
    output logic [2:0]          err_id,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                active_q, idle_q, error_q;
    logic [2:0]          err_id_q;
    logic [UMB_MF_W-1:0] umb_mf_q;
    logic [UMB_VC_W-1:0] umb_vc0_q, umb_vc1_q;
    logic [UMB_D_W-1:0]  umb_d0_q, umb_d1_q;

    // Returns the index of the lowest set bit. When several FIFOs report an
    // error at once, the lowest index wins.
    function automatic logic [2:0] lowest_set(input logic [4:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Next-state logic. In every state the error check comes first, so an
    // error seen together with init goes to ERROR and not to INIT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET:  state_d = S_INIT;  // fifo_error is not looked at here
            S_INIT: begin
                if (|fifo_error)      state_d = S_ERROR;
                else if (init)        state_d = S_INIT;
                else                  state_d = S_IDLE;
            end
            S_IDLE: begin
                if (|fifo_error)      state_d = S_ERROR;
                else if (init)        state_d = S_INIT;
                else if (~&fifo_empty) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (|fifo_error)      state_d = S_ERROR;
                else if (init)        state_d = S_INIT;
                else if (&fifo_empty) state_d = S_IDLE;
            end
            S_ERROR:  state_d = S_ERROR; // only reset_L leaves ERROR
            default:  state_d = S_RESET;
        endcase
    end

    // State, status flags, thresholds and err_id live in one register bank.
    // The flags are decoded from state_d, so they always match state_q.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= S_RESET;
            active_q  <= 1'b0;
            idle_q    <= 1'b0;
            error_q   <= 1'b0;
            err_id_q  <= 3'd0;
            umb_mf_q  <= UMB_MF_W'(DEF_MF);
            umb_vc0_q <= UMB_VC_W'(DEF_VC);
            umb_vc1_q <= UMB_VC_W'(DEF_VC);
            umb_d0_q  <= UMB_D_W'(DEF_D);
            umb_d1_q  <= UMB_D_W'(DEF_D);
        end else begin
            state_q  <= state_d;
            active_q <= (state_d == S_ACTIVE);
            idle_q   <= (state_d == S_IDLE);
            error_q  <= (state_d == S_ERROR);

            // Thresholds load on every edge spent in INIT, whether or not
            // init is high. This guarantees at least one load after reset.
            if (state_q == S_INIT) begin
                umb_mf_q  <= umbral_MF_in;
                umb_vc0_q <= umbral_VC0_in;
                umb_vc1_q <= umbral_VC1_in;
                umb_d0_q  <= umbral_D0_in;
                umb_d1_q  <= umbral_D1_in;
            end

            // err_id is captured only on the edge that enters ERROR.
            if (state_d == S_ERROR && state_q != S_ERROR) begin
                err_id_q <= lowest_set(fifo_error);
            end
        end
    end

    assign state      = state_q;
    assign active_out = active_q;
    assign idle_out   = idle_q;
    assign error_out  = error_q;
    assign err_id     = err_id_q;
    assign umbral_MF  = umb_mf_q;
    assign umbral_VC0 = umb_vc0_q;
    assign umbral_VC1 = umb_vc1_q;
    assign umbral_D0  = umb_d0_q;
    assign umbral_D1  = umb_d1_q;

endmodule
